// File: rtl/mdio_pkg.sv
// Shared MDIO master types and frame constants.
// Clause 22 frame fields and the FSM state encoding.
package mdio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FRAME = 2'd1,
      ST_DONE  = 2'd2
   } mdio_state_e;

   localparam logic [1:0] MDIO_ST    = 2'b01;
   localparam logic [1:0] MDIO_OP_WR = 2'b01;
   localparam logic [1:0] MDIO_OP_RD = 2'b10;
   localparam logic [1:0] MDIO_TA_WR = 2'b10;

   // 32 post-preamble bits; read TA/data are released on the wire.
   function automatic logic [31:0] mdio_frame(
      input logic        wr,
      input logic [4:0]  phy,
      input logic [4:0]  regad,
      input logic [15:0] wdata
   );
      logic [1:0]  op;
      logic [1:0]  ta;
      logic [15:0] dat;
      op  = wr ? MDIO_OP_WR : MDIO_OP_RD;
      ta  = wr ? MDIO_TA_WR : 2'b11;
      dat = wr ? wdata : 16'h0000;
      return {MDIO_ST, op, phy, regad, ta, dat};
   endfunction

endpackage

// File: rtl/mdio_clkgen.sv
// MDC generator: half-period counter running only while run is high.
// Strobes flag the clk_rmii edge at which mdc toggles.
module mdio_clkgen #(
   parameter int CLK_DIV = 10
) (
   input  logic clk_rmii,
   input  logic rst_ni,
   input  logic run,
   output logic mdc,
   output logic rise_stb,
   output logic fall_stb
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          mdc_q, mdc_d;
   logic          wrap;

   assign wrap     = run && (cnt_q == CNT_LAST);
   assign rise_stb = wrap && !mdc_q;
   assign fall_stb = wrap && mdc_q;
   assign mdc      = mdc_q;

   // Count half-periods; hold clock low and counter cleared when stopped.
   always_comb begin
      cnt_d = cnt_q;
      mdc_d = mdc_q;
      if (!run) begin
         cnt_d = '0;
         mdc_d = 1'b0;
      end else if (wrap) begin
         cnt_d = '0;
         mdc_d = !mdc_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter and MDC registers.
   always_ff @(posedge clk_rmii or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         mdc_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         mdc_q <= mdc_d;
      end
   end

endmodule

// File: rtl/rmii_mdio_master.sv
// Clause 22 MDIO master with host request port and link poll engine.
// Bits change at MDC falls; read data is sampled at MDC rises.
module rmii_mdio_master #(
   parameter int CLK_DIV       = 10,
   parameter int PREAMBLE_BITS = 32,
   parameter int POLL_INTERVAL = 50000
) (
   input  logic        clk_rmii,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [4:0]  req_phy_i,
   input  logic [4:0]  req_reg_i,
   input  logic [15:0] req_wdata_i,
   input  logic        pre_sup_i,
   output logic        rsp_valid_o,
   output logic [15:0] rsp_rdata_o,
   output logic        rsp_err_o,
   input  logic        poll_en_i,
   input  logic [4:0]  poll_phy_i,
   input  logic [4:0]  poll_reg_i,
   output logic [15:0] poll_data_o,
   output logic        poll_valid_o,
   output logic        poll_change_o,
   output logic        mdc_o,
   output logic        mdio_o,
   output logic        mdio_t_o,
   input  logic        mdio_i
);

   import mdio_pkg::*;

   localparam int TW = $clog2(POLL_INTERVAL + 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(POLL_INTERVAL - 1);
   localparam logic [5:0] REM_FULL = 6'(PREAMBLE_BITS + 31);

   mdio_state_e    state_q, state_d;
   logic [5:0]     rem_q, rem_d, rem_n;
   logic [31:0]    frame_q, frame_d, ld_frame;
   logic           wr_q, wr_d, ld_wr;
   logic           poll_q, poll_d;
   logic           err_q, err_d;
   logic           mdio_q, mdio_d;
   logic           mdio_t_q, mdio_t_d;
   logic           rdy_q, rdy_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic [15:0]    rsp_rdata_q, rsp_rdata_d;
   logic           rsp_err_q, rsp_err_d;
   logic [15:0]    poll_data_q, poll_data_d;
   logic           poll_valid_q, poll_valid_d;
   logic           poll_chg_q, poll_chg_d;
   logic [TW-1:0]  tmr_q, tmr_d;
   logic           pend_q, pend_d;
   logic           sync1_q, sync2_q;
   logic           start;
   logic           run, rise_stb, fall_stb;

   assign run = (state_q == ST_FRAME);

   mdio_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .clk_rmii (clk_rmii),
      .rst_ni   (rst_ni),
      .run      (run),
      .mdc      (mdc_o),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb)
   );

   assign req_ready_o   = rdy_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_rdata_o   = rsp_rdata_q;
   assign rsp_err_o     = rsp_err_q;
   assign poll_data_o   = poll_data_q;
   assign poll_valid_o  = poll_valid_q;
   assign poll_change_o = poll_chg_q;
   assign mdio_o        = mdio_q;
   assign mdio_t_o      = mdio_t_q;

   // Two-flop synchroniser for the asynchronous MDIO pin.
   always_ff @(posedge clk_rmii or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= mdio_i;
         sync2_q <= sync1_q;
      end
   end

   // FSM next state, arbitration, serialiser and poll bookkeeping.
   always_comb begin
      state_d      = state_q;
      rem_d        = rem_q;
      rem_n        = rem_q - 6'd1;
      frame_d      = frame_q;
      ld_frame     = frame_q;
      ld_wr        = wr_q;
      wr_d         = wr_q;
      poll_d       = poll_q;
      err_d        = err_q;
      mdio_d       = mdio_q;
      mdio_t_d     = mdio_t_q;
      rsp_valid_d  = 1'b0;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_err_d    = rsp_err_q;
      poll_data_d  = poll_data_q;
      poll_valid_d = poll_valid_q;
      poll_chg_d   = 1'b0;
      tmr_d        = tmr_q;
      pend_d       = pend_q;
      start        = 1'b0;

      if (!poll_en_i) begin
         tmr_d  = '0;
         pend_d = 1'b0;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               start    = 1'b1;
               ld_wr    = req_write_i;
               ld_frame = mdio_frame(req_write_i, req_phy_i,
                                     req_reg_i, req_wdata_i);
               poll_d   = 1'b0;
            end else if (pend_q && poll_en_i) begin
               start    = 1'b1;
               ld_wr    = 1'b0;
               ld_frame = mdio_frame(1'b0, poll_phy_i,
                                     poll_reg_i, 16'h0000);
               poll_d   = 1'b1;
               pend_d   = 1'b0;
            end else if (poll_en_i) begin
               if (tmr_q == TMR_LAST) begin
                  tmr_d  = '0;
                  pend_d = 1'b1;
               end else begin
                  tmr_d = tmr_q + TW'(1);
               end
            end
            if (start) begin
               state_d  = ST_FRAME;
               wr_d     = ld_wr;
               frame_d  = ld_frame;
               err_d    = 1'b0;
               tmr_d    = '0;
               rem_d    = pre_sup_i ? 6'd31 : REM_FULL;
               mdio_d   = pre_sup_i ? ld_frame[31] : 1'b1;
               mdio_t_d = 1'b0;
            end
         end
         ST_FRAME: begin
            if (rise_stb && !wr_q) begin
               if (rem_q == 6'd16) begin
                  err_d = sync2_q;
               end
               if (rem_q < 6'd16) begin
                  frame_d[15:0] = {frame_q[14:0], sync2_q};
               end
            end
            if (fall_stb) begin
               if (rem_q == 6'd0) begin
                  state_d  = ST_DONE;
                  mdio_d   = 1'b1;
                  mdio_t_d = 1'b1;
                  if (poll_q) begin
                     if (!err_q) begin
                        poll_chg_d   = !poll_valid_q ||
                                       (frame_q[15:0] != poll_data_q);
                        poll_data_d  = frame_q[15:0];
                        poll_valid_d = 1'b1;
                     end
                  end else begin
                     rsp_valid_d = 1'b1;
                     rsp_err_d   = !wr_q && err_q;
                     if (!wr_q) begin
                        rsp_rdata_d = frame_q[15:0];
                     end
                  end
               end else begin
                  rem_d    = rem_n;
                  mdio_d   = (rem_n > 6'd31) ? 1'b1
                                             : frame_q[rem_n[4:0]];
                  mdio_t_d = !wr_q && (rem_n <= 6'd17);
               end
            end
         end
         ST_DONE: begin
            state_d  = ST_IDLE;
            mdio_t_d = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      rdy_d = (state_d == ST_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk_rmii or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         rem_q        <= '0;
         frame_q      <= '0;
         wr_q         <= 1'b0;
         poll_q       <= 1'b0;
         err_q        <= 1'b0;
         mdio_q       <= 1'b1;
         mdio_t_q     <= 1'b1;
         rdy_q        <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
         poll_data_q  <= '0;
         poll_valid_q <= 1'b0;
         poll_chg_q   <= 1'b0;
         tmr_q        <= '0;
         pend_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rem_q        <= rem_d;
         frame_q      <= frame_d;
         wr_q         <= wr_d;
         poll_q       <= poll_d;
         err_q        <= err_d;
         mdio_q       <= mdio_d;
         mdio_t_q     <= mdio_t_d;
         rdy_q        <= rdy_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
         poll_data_q  <= poll_data_d;
         poll_valid_q <= poll_valid_d;
         poll_chg_q   <= poll_chg_d;
         tmr_q        <= tmr_d;
         pend_q       <= pend_d;
      end
   end

endmodule

// File: tb/tb_rmii_mdio_master.sv
// Directed bench for rmii_mdio_master.
// Small PHY model answers reads; each task checks one scenario.
module tb_rmii_mdio_master;

   localparam int CD = 10;
   localparam int PB = 32;
   localparam int PI = 100;
   localparam int NB = 64;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_write_i = 1'b0;
   logic [4:0]  req_phy_i = '0;
   logic [4:0]  req_reg_i = '0;
   logic [15:0] req_wdata_i = '0;
   logic        pre_sup_i = 1'b0;
   logic        rsp_valid_o;
   logic [15:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        poll_en_i = 1'b0;
   logic [4:0]  poll_phy_i = '0;
   logic [4:0]  poll_reg_i = '0;
   logic [15:0] poll_data_o;
   logic        poll_valid_o;
   logic        poll_change_o;
   logic        mdc_o;
   logic        mdio_o;
   logic        mdio_t_o;
   logic        mdio_i = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   logic        phy_on = 1'b0;
   logic [15:0] phy_data = '0;

   rmii_mdio_master #(
      .CLK_DIV       (CD),
      .PREAMBLE_BITS (PB),
      .POLL_INTERVAL (PI)
   ) dut (
      .clk_rmii      (clk),
      .rst_ni        (rst_ni),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_write_i   (req_write_i),
      .req_phy_i     (req_phy_i),
      .req_reg_i     (req_reg_i),
      .req_wdata_i   (req_wdata_i),
      .pre_sup_i     (pre_sup_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_rdata_o   (rsp_rdata_o),
      .rsp_err_o     (rsp_err_o),
      .poll_en_i     (poll_en_i),
      .poll_phy_i    (poll_phy_i),
      .poll_reg_i    (poll_reg_i),
      .poll_data_o   (poll_data_o),
      .poll_valid_o  (poll_valid_o),
      .poll_change_o (poll_change_o),
      .mdc_o         (mdc_o),
      .mdio_o        (mdio_o),
      .mdio_t_o      (mdio_t_o),
      .mdio_i        (mdio_i)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic phy_val(input int b);
      if (!phy_on || b >= NB) return 1'b1;
      if (b == NB - 17) return 1'b0;
      if (b >= NB - 16) return phy_data[NB - 1 - b];
      return 1'b1;
   endfunction

   // PHY model: bit index restarts at frame start, advances on MDC fall.
   int   bitn = 0;
   logic mdc_p = 1'b0;
   logic rdy_p = 1'b1;
   always @(posedge clk) begin
      int b;
      b = bitn;
      if (rdy_p && !req_ready_o) b = 0;
      else if (mdc_p && !mdc_o) b = bitn + 1;
      bitn   <= b;
      mdc_p  <= mdc_o;
      rdy_p  <= req_ready_o;
      mdio_i <= phy_val(b);
   end

   task automatic issue(input logic wr, input logic [4:0] phy,
                        input logic [4:0] ra, input logic [15:0] wd,
                        input logic ps, output int a);
      @(negedge clk);
      req_valid_i = 1'b1;
      req_write_i = wr;
      req_phy_i   = phy;
      req_reg_i   = ra;
      req_wdata_i = wd;
      pre_sup_i   = ps;
      a = cyc;
      @(negedge clk);
      req_valid_i = 1'b0;
      pre_sup_i   = 1'b0;
   endtask

   // Follows one frame until req_ready_o returns; records observations.
   task automatic run_frame(output int vcyc, output int rcyc,
                            output int frise, output int nrise,
                            output logic [63:0] bits,
                            output logic [63:0] tb,
                            output logic tv, output int nval,
                            output logic tmo);
      logic pm;
      int   n;
      vcyc = -1; rcyc = -1; frise = -1; nrise = 0;
      bits = '0; tb = '0; tv = 1'b0; nval = 0; tmo = 1'b1;
      pm = mdc_o;
      n = 0;
      while (tmo && n < 3000) begin
         @(negedge clk);
         n++;
         if (mdc_o && !pm) begin
            if (frise < 0) frise = cyc;
            nrise++;
            bits = {bits[62:0], mdio_o};
            tb   = {tb[62:0], mdio_t_o};
         end
         pm = mdc_o;
         if (rsp_valid_o) begin
            nval++;
            vcyc = cyc;
            tv = mdio_t_o;
         end
         if (req_ready_o) begin
            rcyc = cyc;
            tmo = 1'b0;
         end
      end
   endtask

   task automatic test_reset;
      n_cmp++;
      if ({req_ready_o, rsp_valid_o, rsp_err_o, poll_valid_o,
           poll_change_o, mdc_o, mdio_o, mdio_t_o} !== 8'b1000_0011) begin
         n_bad++;
         $display("FAIL reset_ctl: got %b want 10000011",
                  {req_ready_o, rsp_valid_o, rsp_err_o, poll_valid_o,
                   poll_change_o, mdc_o, mdio_o, mdio_t_o});
      end
      n_cmp++;
      if (rsp_rdata_o !== 16'h0000 || poll_data_o !== 16'h0000) begin
         n_bad++;
         $display("FAIL reset_data: got %h/%h want 0000/0000",
                  rsp_rdata_o, poll_data_o);
      end
   endtask

   task automatic test_write;
      int a, v, r, fr, nr, nv;
      logic [63:0] bits, tb, exp;
      logic tv, tmo;
      exp = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1140};
      issue(1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, a);
      run_frame(v, r, fr, nr, bits, tb, tv, nv, tmo);
      n_cmp++;
      if (tmo) begin n_bad++; $display("FAIL wr_timeout: no return to idle"); end
      n_cmp++;
      if (bits !== exp) begin
         n_bad++; $display("FAIL wr_bits: got %h want %h", bits, exp);
      end
      n_cmp++;
      if (v - a != 1281) begin
         n_bad++; $display("FAIL wr_latency: got %0d want 1281", v - a);
      end
      n_cmp++;
      if (fr - a != 1 + CD) begin
         n_bad++; $display("FAIL wr_first_rise: got %0d want %0d", fr - a, 1 + CD);
      end
      n_cmp++;
      if (tb !== 64'h0 || nr != 64) begin
         n_bad++; $display("FAIL wr_drive: tri %h rises %0d want 0 / 64", tb, nr);
      end
      n_cmp++;
      if (rsp_err_o !== 1'b0 || nv != 1) begin
         n_bad++; $display("FAIL wr_rsp: err %b pulses %0d want 0 / 1", rsp_err_o, nv);
      end
      n_cmp++;
      if (r - v != 1) begin
         n_bad++; $display("FAIL wr_ready: got %0d want 1", r - v);
      end
   endtask

   task automatic test_read;
      int a, v, r, fr, nr, nv;
      logic [63:0] bits, tb;
      logic [45:0] hdr;
      logic tv, tmo;
      hdr = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, 5'd1};
      phy_on = 1'b1;
      phy_data = 16'h786D;
      issue(1'b0, 5'd1, 5'd1, 16'h0000, 1'b0, a);
      run_frame(v, r, fr, nr, bits, tb, tv, nv, tmo);
      n_cmp++;
      if (tmo) begin n_bad++; $display("FAIL rd_timeout: no return to idle"); end
      n_cmp++;
      if (rsp_rdata_o !== 16'h786D || rsp_err_o !== 1'b0) begin
         n_bad++;
         $display("FAIL rd_data: got %h err %b want 786d err 0", rsp_rdata_o, rsp_err_o);
      end
      n_cmp++;
      if (bits[63:18] !== hdr) begin
         n_bad++; $display("FAIL rd_header: got %h want %h", bits[63:18], hdr);
      end
      n_cmp++;
      if (tb !== 64'h3FFFF || tv !== 1'b1) begin
         n_bad++; $display("FAIL rd_release: tri %h done %b want 3ffff / 1", tb, tv);
      end
      n_cmp++;
      if (v - a != 1281 || nv != 1) begin
         n_bad++; $display("FAIL rd_latency: got %0d (%0d pulses) want 1281", v - a, nv);
      end
   endtask

   task automatic test_nophy;
      int a, v, r, fr, nr, nv;
      logic [63:0] bits, tb;
      logic tv, tmo;
      phy_on = 1'b0;
      issue(1'b0, 5'd7, 5'd1, 16'h0000, 1'b0, a);
      run_frame(v, r, fr, nr, bits, tb, tv, nv, tmo);
      n_cmp++;
      if (tmo || rsp_rdata_o !== 16'hFFFF || rsp_err_o !== 1'b1) begin
         n_bad++;
         $display("FAIL nophy: got %h err %b tmo %b want ffff err 1",
                  rsp_rdata_o, rsp_err_o, tmo);
      end
   endtask

   task automatic test_presup;
      int a, v, r, fr, nr, nv;
      logic [63:0] bits, tb;
      logic [31:0] exp;
      logic tv, tmo;
      exp = {2'b01, 2'b01, 5'd2, 5'd4, 2'b10, 16'hA5C3};
      issue(1'b1, 5'd2, 5'd4, 16'hA5C3, 1'b1, a);
      run_frame(v, r, fr, nr, bits, tb, tv, nv, tmo);
      n_cmp++;
      if (tmo || v - a != 641) begin
         n_bad++; $display("FAIL ps_latency: got %0d tmo %b want 641", v - a, tmo);
      end
      n_cmp++;
      if (nr != 32 || bits[31:0] !== exp) begin
         n_bad++;
         $display("FAIL ps_bits: got %h (%0d rises) want %h (32)", bits[31:0], nr, exp);
      end
   endtask

   task automatic test_poll;
      logic [15:0] seq [3];
      int          expc [3];
      int st, fc, chg, rv, n;
      logic fin;
      seq[0] = 16'h7809; seq[1] = 16'h7809; seq[2] = 16'h780D;
      expc[0] = 1; expc[1] = 0; expc[2] = 1;
      rv = 0;
      phy_on = 1'b1;
      poll_phy_i = 5'd1;
      poll_reg_i = 5'd1;
      phy_data = seq[0];
      @(negedge clk);
      poll_en_i = 1'b1;
      st = cyc;
      for (int i = 0; i < 3; i++) begin
         phy_data = seq[i];
         fc = -1; n = 0;
         while (fc < 0 && n < 500) begin
            @(negedge clk);
            n++;
            if (rsp_valid_o) rv++;
            if (!req_ready_o) fc = cyc;
         end
         n_cmp++;
         if (fc - st != PI + 1) begin
            n_bad++; $display("FAIL poll%0d_gap: got %0d want %0d", i, fc - st, PI + 1);
         end
         chg = 0; n = 0; fin = 1'b0;
         while (!fin && n < 3000) begin
            @(negedge clk);
            n++;
            if (rsp_valid_o) rv++;
            if (poll_change_o) chg++;
            if (req_ready_o) begin
               fin = 1'b1;
               st = cyc;
            end
         end
         n_cmp++;
         if (!fin || chg != expc[i]) begin
            n_bad++;
            $display("FAIL poll%0d_change: got %0d pulses want %0d", i, chg, expc[i]);
         end
         n_cmp++;
         if (poll_data_o !== seq[i] || poll_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL poll%0d_data: got %h valid %b want %h valid 1",
                     i, poll_data_o, poll_valid_o, seq[i]);
         end
      end
      poll_en_i = 1'b0;
      n_cmp++;
      if (rv != 0) begin
         n_bad++; $display("FAIL poll_rsp: got %0d rsp pulses want 0", rv);
      end
   endtask

   task automatic test_back_to_back;
      int a, k, v, r, fr, nr, nv;
      logic [63:0] bits, tb;
      logic tv, tmo;
      phy_on = 1'b1;
      phy_data = 16'h1234;
      repeat (3) @(negedge clk);
      poll_en_i = 1'b1;
      k = cyc;
      while (cyc < k + PI) @(negedge clk);
      req_valid_i = 1'b1;
      req_write_i = 1'b1;
      req_phy_i   = 5'd3;
      req_reg_i   = 5'd0;
      req_wdata_i = 16'h0000;
      a = cyc;
      @(negedge clk);
      req_valid_i = 1'b0;
      run_frame(v, r, fr, nr, bits, tb, tv, nv, tmo);
      n_cmp++;
      if (tmo || nv != 1 || tb !== 64'h0 || v - a != 1281) begin
         n_bad++;
         $display("FAIL arb_host_first: pulses %0d tri %h lat %0d want 1 / 0 / 1281",
                  nv, tb, v - a);
      end
      n_cmp++;
      if (r - v != 1) begin
         n_bad++; $display("FAIL arb_idle: got %0d want 1", r - v);
      end
      @(negedge clk);
      n_cmp++;
      if (req_ready_o !== 1'b0 || mdio_t_o !== 1'b0) begin
         n_bad++;
         $display("FAIL arb_poll_start: ready %b tri %b want 0 / 0", req_ready_o, mdio_t_o);
      end
      run_frame(v, r, fr, nr, bits, tb, tv, nv, tmo);
      poll_en_i = 1'b0;
      n_cmp++;
      if (tmo || nv != 0 || poll_data_o !== 16'h1234 || tb !== 64'h3FFFF) begin
         n_bad++;
         $display("FAIL arb_poll: data %h pulses %0d tri %h want 1234 / 0 / 3ffff",
                  poll_data_o, nv, tb);
      end
   endtask

   task automatic test_reset_mid;
      int a, v, r, fr, nr, nv, n, rises;
      logic [63:0] bits, tb;
      logic tv, tmo, pm;
      issue(1'b1, 5'd1, 5'd0, 16'hFFFF, 1'b0, a);
      rises = 0; n = 0; pm = mdc_o;
      while (rises < 30 && n < 1000) begin
         @(negedge clk);
         n++;
         if (mdc_o && !pm) rises++;
         pm = mdc_o;
      end
      rst_ni = 1'b0;
      #1;
      n_cmp++;
      if (rises != 30 || mdc_o !== 1'b0 || mdio_t_o !== 1'b1 ||
          req_ready_o !== 1'b1 || mdio_o !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_mid: rises %0d mdc %b tri %b ready %b mdio %b want 30 0 1 1 1",
                  rises, mdc_o, mdio_t_o, req_ready_o, mdio_o);
      end
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      phy_on = 1'b1;
      phy_data = 16'hBEEF;
      issue(1'b0, 5'd1, 5'd1, 16'h0000, 1'b0, a);
      run_frame(v, r, fr, nr, bits, tb, tv, nv, tmo);
      n_cmp++;
      if (tmo || rsp_rdata_o !== 16'hBEEF || rsp_err_o !== 1'b0 || v - a != 1281) begin
         n_bad++;
         $display("FAIL rst_then_read: got %h err %b lat %0d want beef 0 1281",
                  rsp_rdata_o, rsp_err_o, v - a);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      test_reset();
      test_write();
      test_read();
      test_nophy();
      test_presup();
      test_poll();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
